// File: rtl/column_neuron_layer.sv
// column_neuron_layer
//
// One column of integrate-and-fire neurons driven by a gamma cycle of T ticks.
// A start pulse in IDLE opens a gamma cycle (RUN), during which every neuron
// ramps its potential by the weights of all inputs that have spiked so far in
// this cycle (ramp response, no leak). A neuron fires once, on the first tick
// its potential reaches THRESHOLD. After tick T-1 a one-cycle DONE state
// emits gamma_done and the block returns to IDLE.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         one-cycle request to begin a gamma cycle (honoured in IDLE only)
//   input_spikes  per-input spike bits for the current tick
//   weights       flat weight array, w[n][i] at offset (n*NUM_INPUTS+i)*WEIGHT_W
//   time_val      current tick in RUN, T otherwise
//   spike_volley  per-neuron fire bits for tick time_val
//   busy          high while in RUN
//   gamma_done    one-cycle pulse closing a gamma cycle

`ifndef NEURONS_PER_LAYER
`define NEURONS_PER_LAYER 4
`endif
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif

module column_neuron_layer #(
    parameter int NUM_INPUTS = 8,
    parameter int WEIGHT_W   = 3,
    parameter int THRESHOLD  = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic [NUM_INPUTS-1:0]                            input_spikes,
    input  logic [`NEURONS_PER_LAYER*NUM_INPUTS*WEIGHT_W-1:0] weights,
    output logic [`LOG_TIME_PERIOD:0]                        time_val,
    output logic [`NEURONS_PER_LAYER-1:0]                    spike_volley,
    output logic                                             busy,
    output logic                                             gamma_done
);

    localparam int N       = `NEURONS_PER_LAYER;
    localparam int LOG_T   = `LOG_TIME_PERIOD;
    localparam int T       = 1 << LOG_T;
    localparam int POT_MAX = THRESHOLD + NUM_INPUTS * ((1 << WEIGHT_W) - 1);
    localparam int POT_W   = $clog2(POT_MAX + 1);

    localparam logic [LOG_T-1:0] TICK_LAST = LOG_T'(T - 1);
    localparam logic [LOG_T:0]   TIME_IDLE = (LOG_T + 1)'(T);
    localparam logic [POT_W-1:0] THR       = POT_W'(THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [LOG_T-1:0]           tick_q, tick_d;
    logic [N-1:0][POT_W-1:0]    pot_q, pot_d;
    logic [N-1:0]               fired_q, fired_d;
    logic [NUM_INPUTS-1:0]      latched_q, latched_d;

    logic [NUM_INPUTS-1:0]      active;
    logic [N-1:0][POT_W-1:0]    drive;

    // Potentials saturate at all-ones so a late ramp can never wrap back
    // below threshold.
    function automatic logic [POT_W-1:0] sat_add(input logic [POT_W-1:0] a,
                                                 input logic [POT_W-1:0] b);
        logic [POT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[POT_W]) begin
            sat_add = '1;
        end else begin
            sat_add = s[POT_W-1:0];
        end
    endfunction

    // An input keeps contributing from its first spike until the gamma cycle
    // ends; the live bit is OR-ed in so a spike counts on its own tick.
    assign active = latched_q | input_spikes;

    // Per-neuron synaptic drive for this tick. Cannot overflow POT_W: the
    // largest possible sum is NUM_INPUTS*(2**WEIGHT_W-1) <= POT_MAX.
    always_comb begin
        drive = '0;
        for (int n = 0; n < N; n++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (active[i]) begin
                    drive[n] = drive[n]
                             + POT_W'(weights[(n*NUM_INPUTS+i)*WEIGHT_W +: WEIGHT_W]);
                end
            end
        end
    end

    // Fire decision is purely from registered state, so a neuron's bit is
    // high for exactly the tick after its potential crossed.
    always_comb begin
        spike_volley = '0;
        if (state_q == S_RUN) begin
            for (int n = 0; n < N; n++) begin
                spike_volley[n] = !fired_q[n] && (pot_q[n] >= THR);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        pot_d      = pot_q;
        fired_d    = fired_q;
        latched_d  = latched_q;
        busy       = 1'b0;
        gamma_done = 1'b0;
        time_val   = TIME_IDLE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    tick_d    = '0;
                    pot_d     = '0;
                    fired_d   = '0;
                    latched_d = '0;
                end
            end

            S_RUN: begin
                busy      = 1'b1;
                time_val  = {1'b0, tick_q};
                latched_d = active;
                fired_d   = fired_q | spike_volley;
                for (int n = 0; n < N; n++) begin
                    pot_d[n] = sat_add(pot_q[n], drive[n]);
                end
                if (tick_q == TICK_LAST) begin
                    state_d = S_DONE;
                end else begin
                    tick_d = tick_q + LOG_T'(1);
                end
            end

            S_DONE: begin
                gamma_done = 1'b1;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            pot_q     <= '0;
            fired_q   <= '0;
            latched_q <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            pot_q     <= pot_d;
            fired_q   <= fired_d;
            latched_q <= latched_d;
        end
    end

endmodule
